// File: rtl/mse_bridge_pkg.sv
// mse_bridge_pkg: shared types and frame geometry for the MSE serial bridge.
// Optional feature macro: MSE_BRIDGE_PARITY_EN appends one odd-parity bit to
// every frame, which lengthens both frame types by one bit.
package mse_bridge_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // Wide enough for the longest frame (26 bits) and the read/shift counts.
  localparam int CNT_W = 5;

`ifdef MSE_BRIDGE_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Frame lengths in clocks: R/nW bit, address, write data, optional parity.
  localparam int WR_BITS = 1 + ADDR_W + DATA_W + PAR_BITS;
  localparam int RD_BITS = 1 + ADDR_W + PAR_BITS;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    WR,
    RD,
    SHIFT
  } state_e;

endpackage

// File: rtl/mse_shift16.sv
// mse_shift16: 16-bit MSB-first shift register with parallel load.
// Load has priority over shift; serial output is always the top bit.
module mse_shift16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic        sin,
  input  logic [15:0] pin,
  output logic [15:0] pout,
  output logic        sout
);

  logic [15:0] sr_q;
  logic [15:0] sr_d;

  // Next value: parallel load, else shift left taking sin into bit 0.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = pin;
    end else if (en) begin
      sr_d = {sr_q[14:0], sin};
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign pout = sr_q;
  assign sout = sr_q[15];

endmodule

// File: rtl/mse_serial_bridge.sv
// mse_serial_bridge: serial frame decoder driving one MSE parallel slot.
// Write frame: R/nW=0, 8 address bits, 16 data bits -> one-clock wr.
// Read frame: R/nW=1, 8 address bits -> rd for RD_WAIT clocks, then 16
// rdata bits returned MSB first on mse_sdo while mse_srdy is high.
// Optional feature macro: MSE_BRIDGE_PARITY_EN (trailing odd-parity bit).
module mse_serial_bridge
  import mse_bridge_pkg::*;
#(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              mse_sdi,
  input  logic              mse_sle,
  output logic              mse_sdo,
  output logic              mse_srdy,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              wr,
  output logic              rd,
  output logic              frame_err
);

  localparam int GAP_W = $clog2(IDLE_GAP + 2);

  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(ADDR_W + DATA_W);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_BITS - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_BITS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_MIN    = GAP_W'(IDLE_GAP);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rnw_q, rnw_d;
  logic               abort_q, abort_d;
  logic               ferr_q, ferr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic               gap_ok;
  logic               par_ok;
  logic               rx_en;
  logic               tx_load;
  logic               tx_en;
  logic [DATA_W-1:0]  rx_pout;
  logic               rx_sout;
  logic [DATA_W-1:0]  tx_pout;
  logic               tx_sout;
  logic               unused_shift;

  // Receive path holds the write data; only shifted while in WDATA.
  mse_shift16 u_rx (
    .clk  (csi_MCLK_clk),
    .rst  (rsi_MRST_reset),
    .load (1'b0),
    .en   (rx_en),
    .sin  (mse_sdi),
    .pin  ('0),
    .pout (rx_pout),
    .sout (rx_sout)
  );

  // Transmit path captures rdata and streams it out MSB first.
  mse_shift16 u_tx (
    .clk  (csi_MCLK_clk),
    .rst  (rsi_MRST_reset),
    .load (tx_load),
    .en   (tx_en),
    .sin  (1'b0),
    .pin  (rdata),
    .pout (tx_pout),
    .sout (tx_sout)
  );

  assign unused_shift = ^{rx_sout, tx_pout};

  // Count consecutive low clocks of mse_sle, saturating at IDLE_GAP.
  always_comb begin
    gap_d = gap_q;
    if (mse_sle) begin
      gap_d = '0;
    end else if (gap_q < GAP_MIN) begin
      gap_d = gap_q + 1'b1;
    end
  end

  assign gap_ok = (gap_q >= GAP_MIN);

`ifdef MSE_BRIDGE_PARITY_EN
  logic par_q, par_d;

  // Running XOR of every frame bit; restarts on the first bit in IDLE.
  always_comb begin
    par_d = par_q;
    if (state_q == IDLE) begin
      par_d = mse_sdi;
    end else if (state_q == HDR || state_q == WDATA) begin
      par_d = par_q ^ mse_sdi;
    end
  end

  // Parity accumulator register.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  // Odd parity: XOR over all bits including the parity bit must be 1.
  assign par_ok = par_q ^ mse_sdi;
`else
  assign par_ok = 1'b1;
`endif

  // Frame sequencing: next state, counters, address shift and strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    ferr_d  = 1'b0;
    rx_en   = 1'b0;
    tx_load = 1'b0;
    tx_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mse_sle && gap_ok) begin
          rnw_d   = mse_sdi;
          cnt_d   = CNT_W'(1);
          state_d = HDR;
        end
      end

      HDR: begin
        if (!mse_sle) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          if (cnt_q <= ADDR_LAST) begin
            addr_d = {addr_q[ADDR_W-2:0], mse_sdi};
          end
          cnt_d = cnt_q + 1'b1;
          // A read's parity bit (when present) is taken here, after the address.
          if (rnw_q && cnt_q == RD_LAST) begin
            if (par_ok) begin
              cnt_d   = '0;
              abort_d = 1'b0;
              state_d = RD;
            end else begin
              ferr_d  = 1'b1;
              state_d = IDLE;
            end
          end else if (!rnw_q && cnt_q == ADDR_LAST) begin
            state_d = WDATA;
          end
        end
      end

      WDATA: begin
        if (!mse_sle) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rx_en = (cnt_q <= DATA_LAST);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == WR_LAST) begin
            if (par_ok) begin
              state_d = WR;
            end else begin
              ferr_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      WR: begin
        state_d = IDLE;
      end

      // An early mse_sle fall still lets rd run its full length; the error
      // is flagged once and the serial return is skipped.
      RD: begin
        if (!mse_sle && !abort_q) begin
          ferr_d  = 1'b1;
          abort_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WAIT_LAST) begin
          tx_load = 1'b1;
          cnt_d   = '0;
          state_d = (abort_q || !mse_sle) ? IDLE : SHIFT;
        end
      end

      SHIFT: begin
        if (!mse_sle) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tx_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHIFT_LAST) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      abort_q <= 1'b0;
      ferr_q  <= 1'b0;
      addr_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      abort_q <= abort_d;
      ferr_q  <= ferr_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
    end
  end

  assign wr        = (state_q == WR);
  assign rd        = (state_q == RD);
  assign mse_srdy  = (state_q == SHIFT);
  assign mse_sdo   = mse_srdy & tx_sout;
  assign address   = addr_q;
  assign wdata     = rx_pout;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_mse_serial_bridge.sv
// tb_mse_serial_bridge: directed frames with a cycle-indexed scoreboard.
// Each frame task works out, from frame-level timing rules, in which clock
// every strobe, serial bit and error pulse must appear; every clock the
// outputs are compared against that table. Literal checks pin key timings.
`timescale 1ns/1ps
module tb_mse_serial_bridge;

  localparam int RDW = 2;
  localparam int GAP = 1;
`ifdef MSE_BRIDGE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L_WR   = 25 + PB;
  localparam int L_RD   = 9 + PB;
  localparam int W_CLK  = 26 + PB;
  localparam int RD_CLK = 10 + PB;
  localparam int NSLOT  = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdi;
  logic        sle;
  logic        sdo;
  logic        srdy;
  logic [7:0]  address;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        wr;
  logic        rd;
  logic        frame_err;

  mse_serial_bridge #(
    .RD_WAIT  (RDW),
    .IDLE_GAP (GAP)
  ) dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .mse_sdi        (sdi),
    .mse_sle        (sle),
    .mse_sdo        (sdo),
    .mse_srdy       (srdy),
    .address        (address),
    .wdata          (wdata),
    .rdata          (rdata),
    .wr             (wr),
    .rd             (rd),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  bit          exp_wr   [NSLOT];
  bit          exp_rd   [NSLOT];
  bit          exp_srdy [NSLOT];
  bit          exp_sdo  [NSLOT];
  bit          exp_ferr [NSLOT];
  logic [7:0]  exp_addr [NSLOT];
  logic [15:0] exp_wd   [NSLOT];

  int          errs = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  int          cur = 0;
  int          last_s0 = 0;
  int          obs_wr = -1;
  int          obs_rd_first = -1;
  int          obs_ferr = -1;
  int          srdy_cnt = 0;
  logic [15:0] sdo_word = '0;
  bit          rd_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at clock %0d: got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare this clock's outputs.
  task automatic step();
    @(negedge clk);
    cur = edge_n + 1;
    if (chk_en && cur < NSLOT) begin
      chk("wr", wr, exp_wr[cur]);
      chk("rd", rd, exp_rd[cur]);
      chk("srdy", srdy, exp_srdy[cur]);
      chk("frame_err", frame_err, exp_ferr[cur]);
      chk("wr_rd_exclusive", wr & rd, 0);
      if (exp_wr[cur] || exp_rd[cur]) chk("address", address, exp_addr[cur]);
      if (exp_wr[cur]) chk("wdata", wdata, exp_wd[cur]);
      if (exp_srdy[cur]) chk("sdo", sdo, exp_sdo[cur]);
    end
    if (wr) obs_wr = cur;
    if (rd && !rd_prev) obs_rd_first = cur;
    rd_prev = rd;
    if (frame_err) obs_ferr = cur;
    if (srdy) begin
      srdy_cnt++;
      sdo_word = {sdo_word[14:0], sdo};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      sle = 1'b0;
      sdi = 1'b0;
    end
  endtask

  // Drive one frame. drop_at >= 0 lowers mse_sle at that bit index; rst_at
  // >= 0 pulses reset at that bit index; ign marks frames the bridge must
  // not react to. mse_sle is left high; the caller lowers it afterwards.
  task automatic frame(input bit rnw, input logic [7:0] a, input logic [15:0] d,
                       input int drop_at, input bit bad_par, input int extra,
                       input bit ign, input int rst_at);
    logic [31:0] bits;
    int n, hi, s0, f, sh;
    bit p;
    bits = '0;
    bits[0] = rnw;
    for (int i = 0; i < 8; i++) bits[1 + i] = a[7 - i];
    if (!rnw) for (int i = 0; i < 16; i++) bits[9 + i] = d[15 - i];
    n = rnw ? L_RD : L_WR;
    p = 1'b1;
    for (int i = 0; i < n - PB; i++) p = p ^ bits[i];
    if (PB == 1) bits[n - 1] = p ^ bad_par;
    hi = rnw ? n + RDW + 16 + extra : n + extra;
    if (drop_at >= 0) hi = drop_at;
    if (rnw) rdata = d;
    for (int i = 0; i < hi; i++) begin
      step();
      if (i == 0) begin
        s0 = cur;
        last_s0 = s0;
        f = s0 + hi;
        if (!ign) begin
          if (drop_at >= 0 && drop_at < n) begin
            exp_ferr[f + 1] = 1'b1;
          end else if (bad_par && PB == 1) begin
            exp_ferr[s0 + n] = 1'b1;
          end else if (!rnw) begin
            exp_wr[s0 + n]   = 1'b1;
            exp_addr[s0 + n] = a;
            exp_wd[s0 + n]   = d;
          end else begin
            for (int k = 0; k < RDW; k++) begin
              exp_rd[s0 + n + k]   = 1'b1;
              exp_addr[s0 + n + k] = a;
            end
            sh = s0 + n + RDW;
            for (int k = 0; k < 16; k++) begin
              if (sh + k <= f) begin
                exp_srdy[sh + k] = 1'b1;
                exp_sdo[sh + k]  = d[15 - k];
              end
            end
            if (f <= sh + 15) exp_ferr[f + 1] = 1'b1;
          end
        end
      end
      if (rst_at >= 0 && i == rst_at) begin
        chk("pre_reset_address", address, a);
        rst = 1'b1;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("reset_address", address, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_sdo", sdo, 0);
        rst = 1'b0;
      end
      sle = 1'b1;
      sdi = (i < n) ? bits[i] : 1'($urandom_range(1));
    end
  endtask

  int wr_before;
  int srdy_before;

  initial begin
    rst = 1'b1; sle = 1'b0; sdi = 1'b0; rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_wr", wr, 0);
    chk("reset_rd", rd, 0);
    chk("reset_srdy", srdy, 0);
    chk("reset_sdo", sdo, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_address", address, 0);
    chk("reset_wdata", wdata, 0);
    chk_en = 1'b1;
    idle(3);

    // Plain write.
    frame(1'b0, 8'h3C, 16'hA55A, -1, 1'b0, 0, 1'b0, -1);
    idle(3);
    chk("write_wr_clock", obs_wr - last_s0 + 1, W_CLK);
    chk("write_addr_held", address, 8'h3C);
    chk("write_wdata_held", wdata, 16'hA55A);

    // Plain read.
    srdy_before = srdy_cnt;
    frame(1'b1, 8'h07, 16'hBEEF, -1, 1'b0, 0, 1'b0, -1);
    idle(2);
    chk("read_rd_clock", obs_rd_first - last_s0 + 1, RD_CLK);
    chk("read_sdo_word", sdo_word, 16'hBEEF);
    chk("read_srdy_len", srdy_cnt - srdy_before, 16);

    // Write aborted after 12 bits, then a normal write with trailing bits.
    wr_before = obs_wr;
    frame(1'b0, 8'h5A, 16'hFFFF, 12, 1'b0, 0, 1'b0, -1);
    idle(2);
    chk("abort_ferr_clock", obs_ferr - last_s0 + 1, 14);
    chk("abort_no_wr", obs_wr, wr_before);
    frame(1'b0, 8'h81, 16'h1234, -1, 1'b0, 3, 1'b0, -1);
    idle(1);

    // Back-to-back with minimum gap; a zero-gap frame is ignored.
    frame(1'b0, 8'h10, 16'h0F0F, -1, 1'b0, 0, 1'b0, -1);
    idle(1);
    frame(1'b1, 8'h22, 16'h5AA5, -1, 1'b0, 0, 1'b0, -1);
    wr_before = obs_wr;
    frame(1'b0, 8'h55, 16'hFFFF, -1, 1'b0, 0, 1'b1, -1);
    idle(1);
    chk("zero_gap_ignored", obs_wr, wr_before);
    frame(1'b1, 8'hC3, 16'h0001, -1, 1'b0, 0, 1'b0, -1);
    idle(2);

    // Reset during write data bit 5.
    wr_before = obs_wr;
    frame(1'b0, 8'hFF, 16'hFFFF, -1, 1'b0, 0, 1'b1, 14);
    idle(3);
    chk("reset_no_wr", obs_wr, wr_before);

    // Read with mse_sle dropped in the rd window, then during SHIFT.
    frame(1'b1, 8'h44, 16'h1357, L_RD, 1'b0, 0, 1'b0, -1);
    idle(2);
    srdy_before = srdy_cnt;
    frame(1'b1, 8'h9E, 16'hC0DE, L_RD + RDW + 4, 1'b0, 0, 1'b0, -1);
    idle(3);
    chk("trunc_srdy_len", srdy_cnt - srdy_before, 5);

`ifdef MSE_BRIDGE_PARITY_EN
    wr_before = obs_wr;
    frame(1'b0, 8'h3C, 16'hA55A, -1, 1'b1, 0, 1'b0, -1);
    idle(2);
    chk("bad_parity_ferr_clock", obs_ferr - last_s0 + 1, 27);
    chk("bad_parity_no_wr", obs_wr, wr_before);
`endif

    // Recovery write.
    frame(1'b0, 8'hE7, 16'h8001, -1, 1'b0, 0, 1'b0, -1);
    idle(4);
    chk("final_addr", address, 8'hE7);
    chk("final_wdata", wdata, 16'h8001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
